// File: rtl/dqpsk_pkg.sv
// Shared definitions for the DQPSK modulator path: dibit type, mapper FSM
// state encoding and the axis sign convention, which the demodulator slicer
// uses as well.
package dqpsk_pkg;

  // One relative-code dibit per symbol, as produced by the differential encoder.
  typedef logic [1:0] dibit_t;

  // Mapper FSM state encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Axis sign convention: a dibit bit of SIGN_NEG places the point on the
  // negative side of that axis. din[1] selects I, din[0] selects Q, giving
  // 00=(+,+), 10=(-,+), 11=(-,-), 01=(+,-), i.e. +90 degrees per step in the
  // order 00->10->11->01.
  localparam logic SIGN_POS = 1'b0;
  localparam logic SIGN_NEG = 1'b1;

  // True when the I component of the dibit is negative.
  function automatic logic i_is_neg(input dibit_t d);
    return d[1] == SIGN_NEG;
  endfunction

  // True when the Q component of the dibit is negative.
  function automatic logic q_is_neg(input dibit_t d);
    return d[0] == SIGN_NEG;
  endfunction

endpackage

// File: rtl/sym_phase_cnt.sv
// Sample-phase counter within a symbol: counts 0..OSR-1 on en and wraps,
// with a synchronous clear that has priority over counting.
module sym_phase_cnt #(
  parameter int OSR = 8,
  parameter int PW  = $clog2(OSR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  output logic [PW-1:0] phase,
  output logic          at_zero
);

  localparam logic [PW-1:0] LAST = PW'(OSR - 1);

  // Modulo-OSR phase register; clear wins over enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= '0;
    end else if (clr) begin
      phase <= '0;
    end else if (en) begin
      phase <= (phase == LAST) ? '0 : phase + PW'(1);
    end
  end

  assign at_zero = (phase == '0);

endmodule

// File: rtl/dqpsk_iq_mapper.sv
// DQPSK I/Q mapper: buffers one dibit from the differential encoder, maps it
// to a signed constellation point and emits OSR samples per symbol on the
// sample clock-enable. An empty buffer at a symbol boundary in RUN raises a
// one-cycle underrun pulse and returns to IDLE, which emits (0,0).
//
// Build option: define ZERO_STUFF_EN to emit the point only on the first
// sample of each symbol and (0,0) on the remaining OSR-1 samples (impulse
// train for an interpolating FIR). Left undefined, the point is held for all
// OSR samples (rectangular NRZ).
//
// Handshake: a dibit transfers on a clk edge where din_valid && din_ready.
// din_ready is registered and equals "buffer empty"; once a dibit is taken
// din_ready drops on the next cycle and stays low until the FSM consumes the
// dibit. din_valid may be held high; it is only sampled together with
// din_ready, so nothing is taken twice.
module dqpsk_iq_mapper
  import dqpsk_pkg::*;
#(
  parameter int OSR   = 8,
  parameter int AMP_W = 8,
  parameter int AMP   = 100
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     samp_en,
  input  logic                     din_valid,
  input  dibit_t                   din,
  output logic                     din_ready,
  output logic signed [AMP_W-1:0]  i_out,
  output logic signed [AMP_W-1:0]  q_out,
  output logic                     dout_valid,
  output logic                     sym_start,
  output logic                     underrun,
  output logic [0:0]               dbg_state,
  output logic [$clog2(OSR)-1:0]   dbg_phase
);

  localparam int PW = $clog2(OSR);

  // Constellation levels; AMP is bounded so -AMP never reaches -2^(AMP_W-1).
  localparam logic signed [AMP_W-1:0] AMP_P = AMP_W'(AMP);
  localparam logic signed [AMP_W-1:0] AMP_N = -AMP_P;

  logic [0:0]          state;
  dibit_t              buf_q;
  dibit_t              sym_reg;
  logic                full;
  logic                accept;
  logic                take_sym;
  logic                go_idle;
  logic                cnt_en;
  logic                cnt_clr;
  logic [PW-1:0]       phase;
  logic                at_zero;

  logic signed [AMP_W-1:0] nxt_i;
  logic signed [AMP_W-1:0] nxt_q;
  logic                    nxt_ss;
  logic                    nxt_ur;

  // Axis level for a sign decision.
  function automatic logic signed [AMP_W-1:0] axis_level(input logic neg);
    return neg ? AMP_N : AMP_P;
  endfunction

  assign full   = ~din_ready;
  assign accept = din_valid & din_ready;

  // A new symbol is taken at phase 0 (always the case in IDLE) when a dibit
  // is buffered; an empty buffer at a RUN symbol boundary is an underrun.
  assign take_sym = samp_en & at_zero & full;
  assign go_idle  = samp_en & (state == ST_RUN) & at_zero & ~full;

  // Phase advances on every RUN sample and on the IDLE->RUN start sample.
  assign cnt_en  = samp_en & ((state == ST_RUN) | full);
  assign cnt_clr = go_idle;

  sym_phase_cnt #(
    .OSR (OSR),
    .PW  (PW)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .en      (cnt_en),
    .clr     (cnt_clr),
    .phase   (phase),
    .at_zero (at_zero)
  );

  // FSM: IDLE until a symbol is taken, RUN until a boundary finds no dibit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (take_sym) begin
      state <= ST_RUN;
    end else if (go_idle) begin
      state <= ST_IDLE;
    end
  end

  // One-entry input buffer; accept and consume never coincide because
  // accept needs an empty buffer and consume needs a full one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      din_ready <= 1'b1;
      buf_q     <= '0;
    end else if (accept) begin
      din_ready <= 1'b0;
      buf_q     <= din;
    end else if (take_sym) begin
      din_ready <= 1'b1;
    end
  end

  // Current symbol, held for the remaining samples of the symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_reg <= '0;
    end else if (take_sym) begin
      sym_reg <= buf_q;
    end
  end

  // Sample selection for the upcoming samp_en cycle.
  always_comb begin
    nxt_i  = '0;
    nxt_q  = '0;
    nxt_ss = 1'b0;
    nxt_ur = 1'b0;
    if (take_sym) begin
      nxt_i  = axis_level(i_is_neg(buf_q));
      nxt_q  = axis_level(q_is_neg(buf_q));
      nxt_ss = 1'b1;
    end else if ((state == ST_RUN) && !at_zero) begin
`ifdef ZERO_STUFF_EN
      nxt_i = '0;
      nxt_q = '0;
`else
      nxt_i = axis_level(i_is_neg(sym_reg));
      nxt_q = axis_level(q_is_neg(sym_reg));
`endif
    end else if (go_idle) begin
      nxt_ur = 1'b1;
    end
  end

  // Registered outputs: strobes follow samp_en by one cycle, samples hold
  // their value between strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_out      <= '0;
      q_out      <= '0;
      dout_valid <= 1'b0;
      sym_start  <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      dout_valid <= samp_en;
      sym_start  <= samp_en & nxt_ss;
      underrun   <= samp_en & nxt_ur;
      if (samp_en) begin
        i_out <= nxt_i;
        q_out <= nxt_q;
      end
    end
  end

  assign dbg_state = state;
  assign dbg_phase = phase;

endmodule

// File: tb/tb_dqpsk_iq_mapper.sv
// Testbench for dqpsk_iq_mapper (OSR=4, AMP=100, AMP_W=8). Works with and
// without ZERO_STUFF_EN defined.
module tb_dqpsk_iq_mapper;

  localparam int OSR   = 4;
  localparam int AMP_W = 8;
  localparam int AMP   = 100;
  localparam int PW    = $clog2(OSR);
`ifdef ZERO_STUFF_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic samp_en = 1'b0;
  logic din_valid = 1'b0;
  logic [1:0] din = 2'b00;

  logic                    din_ready;
  logic signed [AMP_W-1:0] i_out;
  logic signed [AMP_W-1:0] q_out;
  logic                    dout_valid;
  logic                    sym_start;
  logic                    underrun;
  logic [0:0]              dbg_state;
  logic [PW-1:0]           dbg_phase;

  always #5 clk = ~clk;

  dqpsk_iq_mapper #(
    .OSR   (OSR),
    .AMP_W (AMP_W),
    .AMP   (AMP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .samp_en    (samp_en),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .i_out      (i_out),
    .q_out      (q_out),
    .dout_valid (dout_valid),
    .sym_start  (sym_start),
    .underrun   (underrun),
    .dbg_state  (dbg_state),
    .dbg_phase  (dbg_phase)
  );

  // samp_en: every 2nd clk by default, every clk when samp_div == 1.
  int samp_div = 2;
  initial begin
    forever begin
      @(negedge clk);
      if (samp_div == 1) samp_en = 1'b1;
      else               samp_en = ~samp_en;
    end
  end

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;
  logic [1:0] exp_q[$];
  int log_i[$];
  int log_q[$];
  int log_ss[$];
  int log_ur[$];

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Constellation point per dibit value (index = dibit): 00=(+,+), 01=(+,-),
  // 10=(-,+), 11=(-,-).
  int quad_i[4] = '{AMP, AMP, -AMP, -AMP};
  int quad_q[4] = '{AMP, -AMP, AMP, -AMP};

  bit m_running;
  int m_emitted;   // samples already emitted in the current symbol, mod OSR
  int m_sym;
  bit m_full;
  int m_buf;
  int e_i, e_q;
  bit e_dv, e_ss, e_ur;

  task automatic model_reset();
    m_running = 0; m_emitted = 0; m_sym = 0; m_full = 0; m_buf = 0;
    e_i = 0; e_q = 0; e_dv = 0; e_ss = 0; e_ur = 0;
  endtask

  task automatic start_symbol();
    m_sym     = m_buf;
    m_full    = 0;
    m_running = 1;
    m_emitted = 1 % OSR;
    e_ss      = 1;
    e_i       = quad_i[m_sym];
    e_q       = quad_q[m_sym];
  endtask

  task automatic model_step();
    bit was_full;
    was_full = m_full;
    e_dv = samp_en; e_ss = 0; e_ur = 0;
    if (samp_en) begin
      if (!m_running) begin
        if (m_full) start_symbol();
        else begin e_i = 0; e_q = 0; end
      end else if (m_emitted != 0) begin
        e_i = ZS ? 0 : quad_i[m_sym];
        e_q = ZS ? 0 : quad_q[m_sym];
        m_emitted = (m_emitted + 1) % OSR;
      end else if (m_full) begin
        start_symbol();
      end else begin
        e_ur = 1; e_i = 0; e_q = 0; m_running = 0;
      end
    end
    if (din_valid && !was_full) begin
      m_full = 1;
      m_buf  = din;
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    if (!rst) model_reset();
    else      model_step();
    #1;
    chk("din_ready", din_ready, !m_full);
    chk("dout_valid", dout_valid, e_dv);
    chk("sym_start", sym_start, e_ss);
    chk("underrun", underrun, e_ur);
    chk("i_out", i_out, e_i);
    chk("q_out", q_out, e_q);
    chk("state", dbg_state, m_running);
    chk("phase", dbg_phase, m_running ? m_emitted : 0);
    if (rst && dout_valid) begin
      log_i.push_back(i_out);
      log_q.push_back(q_out);
      log_ss.push_back(sym_start);
      log_ur.push_back(underrun);
      if (sym_start) begin
        if (exp_q.size() == 0) chk("sb_unexpected_symbol", 1, 0);
        else chk("sb_dibit", ((i_out < 0) ? 2 : 0) + ((q_out < 0) ? 1 : 0), exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at a negedge; returns at a negedge after the dibit was taken.
  task automatic send_dibit(input logic [1:0] d);
    int n;
    n = 0;
    din = d;
    din_valid = 1'b1;
    while (din_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) chk("send_timeout", 0, 1);
    else exp_q.push_back(d);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_i.delete(); log_q.delete(); log_ss.delete(); log_ur.delete();
  endtask

  function automatic int first_start();
    for (int i = 0; i < log_ss.size(); i++) if (log_ss[i] == 1) return i;
    return -1;
  endfunction

  // Checks one logged sample against literal values.
  task automatic chk_sample(input string tag, input int idx, input int ei, input int eq,
                            input int ess, input int eur);
    if (idx < 0 || idx >= log_i.size()) begin
      chk({tag, "_missing"}, idx, -1);
    end else begin
      chk({tag, "_i"}, log_i[idx], ei);
      chk({tag, "_q"}, log_q[idx], eq);
      chk({tag, "_ss"}, log_ss[idx], ess);
      chk({tag, "_ur"}, log_ur[idx], eur);
    end
  endtask

  // ---------------- stimulus ----------------
  int lit_i[4] = '{100, -100, -100, 100};
  int lit_q[4] = '{100, 100, -100, -100};
  int lit3_i[4];
  int k, n, cnt;

  initial begin
    // reset values
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", din_ready, 1);
    chk("rst_i", i_out, 0);
    chk("rst_dv", dout_valid, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // map: 00,10,11,01 back to back
    clear_log();
    send_dibit(2'b00); send_dibit(2'b10); send_dibit(2'b11); send_dibit(2'b01);
    repeat (48) @(negedge clk);
    k = first_start();
    for (int j = 0; j < 16; j++)
      chk_sample("map", (k < 0) ? -1 : k + j,
                 (ZS && (j % 4 != 0)) ? 0 : lit_i[j / 4],
                 (ZS && (j % 4 != 0)) ? 0 : lit_q[j / 4],
                 (j % 4 == 0) ? 1 : 0, 0);
    chk_sample("map_end", (k < 0) ? -1 : k + 16, 0, 0, 0, 1);

    // single 11 symbol, stuffed vs held
`ifdef ZERO_STUFF_EN
    lit3_i = '{-100, 0, 0, 0};
`else
    lit3_i = '{-100, -100, -100, -100};
`endif
    clear_log();
    send_dibit(2'b11);
    repeat (20) @(negedge clk);
    k = first_start();
    for (int j = 0; j < 4; j++)
      chk_sample("zs", (k < 0) ? -1 : k + j, lit3_i[j], lit3_i[j], (j == 0) ? 1 : 0, 0);

    // underrun after a single 10 symbol
    clear_log();
    send_dibit(2'b10);
    repeat (40) @(negedge clk);
    k = first_start();
    for (int j = 0; j < 4; j++)
      chk_sample("ur_sym", (k < 0) ? -1 : k + j, (ZS && j != 0) ? 0 : -100,
                 (ZS && j != 0) ? 0 : 100, (j == 0) ? 1 : 0, 0);
    chk_sample("ur_pulse", (k < 0) ? -1 : k + 4, 0, 0, 0, 1);
    cnt = 0;
    foreach (log_ur[i]) cnt += log_ur[i];
    chk("ur_count", cnt, 1);
    chk("ur_state_idle", dbg_state, 0);

    // reset mid-run with a dibit buffered
    send_dibit(2'b01);
    send_dibit(2'b10);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", din_ready, 1);
    chk("mid_rst_i", i_out, 0);
    chk("mid_rst_q", q_out, 0);
    chk("mid_rst_ss", sym_start, 0);
    chk("mid_rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    clear_log();
    rst = 1'b1;
    n = 0;
    while (log_i.size() == 0 && n < 10) begin @(negedge clk); n++; end
    chk_sample("post_rst", 0, 0, 0, 0, 0);
    repeat (20) @(negedge clk);
    cnt = 0;
    foreach (log_ss[i]) cnt += log_ss[i];
    chk("post_rst_no_resume", cnt, 0);

    // backpressure: 256 random dibits with din_valid kept high
    for (int j = 0; j < 256; j++) send_dibit(2'($urandom_range(0, 3)));
    repeat (40) @(negedge clk);
    chk("sb_drained", exp_q.size(), 0);

    // samp_en on consecutive cycles
    samp_div = 1;
    for (int j = 0; j < 8; j++) send_dibit(2'($urandom_range(0, 3)));
    repeat (20) @(negedge clk);
    chk("sb_drained_fast", exp_q.size(), 0);
    samp_div = 2;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1);
  end

endmodule
